// File: rtl/mem_arb_pkg.sv
// Shared memory-port constants and the channel-id width helper.
// No logic; imported by the arbiter and its ID FIFO users.
package mem_arb_pkg;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;

    // A single channel still needs a 1-bit id so the FIFO has a real width.
    function automatic int idw(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order channel-id FIFO; push/pop take effect at the clock edge, head is read combinationally.
// No internal backpressure: the caller must not push when full_o or pop when empty_o.
module id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_i  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        if (push_i && !pop_i)
            cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter of NCH requesters onto one memory port; request and response paths are zero-latency.
// A stalled grant is locked until accepted; new requests are refused while MAX_OUT responses are pending.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NCH-1:0]               cli_req_valid,
    output logic [NCH-1:0]               cli_req_ready,
    input  logic [NCH*AW-1:0]            cli_req_addr,
    input  logic [NCH*DW-1:0]            cli_req_data,
    input  logic [NCH-1:0]               cli_req_fcn,
    input  logic [NCH*3-1:0]             cli_req_typ,
    output logic [NCH-1:0]               cli_resp_valid,
    output logic [DW-1:0]                cli_resp_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [AW-1:0]                mem_req_addr,
    output logic [DW-1:0]                mem_req_data,
    output logic                         mem_req_fcn,
    output logic [2:0]                   mem_req_typ,
    input  logic                         mem_resp_valid,
    input  logic [DW-1:0]                mem_resp_data,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         resp_err
);
    localparam int IW = idw(NCH);

    logic          en_q;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic [IW-1:0] rr_q, rr_d;
    logic          err_q, err_d;
    logic [IW-1:0] scan_id, grant, head_id;
    logic          scan_found, gvld, accept, pop, full, empty;

    always_comb begin
        int idx;
        idx        = 0;
        scan_found = 1'b0;
        scan_id    = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_q) + k) % NCH;
            for (int i = 0; i < NCH; i++) begin
                if (!scan_found && i == idx && cli_req_valid[i]) begin
                    scan_found = 1'b1;
                    scan_id    = IW'(i);
                end
            end
        end

        grant        = lock_q ? lock_id_q : scan_id;
        gvld         = 1'b0;
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_req_fcn  = M_XRD;
        mem_req_typ  = MT_X;
        for (int i = 0; i < NCH; i++) begin
            if (grant == IW'(i)) begin
                gvld         = cli_req_valid[i];
                mem_req_addr = cli_req_addr[i*AW +: AW];
                mem_req_data = cli_req_data[i*DW +: DW];
                mem_req_fcn  = cli_req_fcn[i];
                mem_req_typ  = cli_req_typ[i*3 +: 3];
            end
        end

        // Full is checked on the registered count, so a same-cycle pop never frees a slot early.
        mem_req_valid = en_q & gvld & ~full;
        accept        = mem_req_valid & mem_req_ready;
        pop           = en_q & mem_resp_valid & ~empty;

        cli_req_ready  = '0;
        cli_resp_valid = '0;
        for (int i = 0; i < NCH; i++) begin
            cli_req_ready[i]  = accept && (grant == IW'(i));
            cli_resp_valid[i] = pop && (head_id == IW'(i));
        end
        cli_resp_data = pop ? mem_resp_data : '0;
    end

    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            rr_d   = (grant == IW'(NCH-1)) ? '0 : grant + 1'b1;
            lock_d = 1'b0;
        end else if (mem_req_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
        err_d = err_q | (mem_resp_valid & empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            en_q      <= 1'b1;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    assign resp_err = err_q;

    id_fifo #(
        .W     (IW),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (accept),
        .din_i   (grant),
        .pop_i   (pop),
        .head_o  (head_id),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding)
    );

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
    import mem_arb_pkg::*;

    localparam int NCH     = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_OUT = 4;

    logic                         clk;
    logic                         reset_n;
    logic [NCH-1:0]               cli_req_valid;
    logic [NCH-1:0]               cli_req_ready;
    logic [NCH*AW-1:0]            cli_req_addr;
    logic [NCH*DW-1:0]            cli_req_data;
    logic [NCH-1:0]               cli_req_fcn;
    logic [NCH*3-1:0]             cli_req_typ;
    logic [NCH-1:0]               cli_resp_valid;
    logic [DW-1:0]                cli_resp_data;
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [AW-1:0]                mem_req_addr;
    logic [DW-1:0]                mem_req_data;
    logic                         mem_req_fcn;
    logic [2:0]                   mem_req_typ;
    logic                         mem_resp_valid;
    logic [DW-1:0]                mem_resp_data;
    logic [$clog2(MAX_OUT+1)-1:0] outstanding;
    logic                         resp_err;

    int errors = 0;
    int checks = 0;

    mem_port_arb #(
        .NCH(NCH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cli_req_valid  (cli_req_valid),
        .cli_req_ready  (cli_req_ready),
        .cli_req_addr   (cli_req_addr),
        .cli_req_data   (cli_req_data),
        .cli_req_fcn    (cli_req_fcn),
        .cli_req_typ    (cli_req_typ),
        .cli_resp_valid (cli_resp_valid),
        .cli_resp_data  (cli_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_fcn    (mem_req_fcn),
        .mem_req_typ    (mem_req_typ),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .outstanding    (outstanding),
        .resp_err       (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] oh(input int i);
        logic [NCH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [AW-1:0] caddr(input int ch);
        return 32'h1000_0000 + AW'(ch * 16);
    endfunction

    task automatic clr_inputs();
        cli_req_valid  = '0;
        cli_req_addr   = '0;
        cli_req_data   = '0;
        cli_req_fcn    = '0;
        cli_req_typ    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic f, input logic [2:0] t);
        cli_req_valid[ch]          = 1'b1;
        cli_req_addr[ch*AW +: AW]  = a;
        cli_req_data[ch*DW +: DW]  = d;
        cli_req_fcn[ch]            = f;
        cli_req_typ[ch*3 +: 3]     = t;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        next_cyc();
    endtask

    task automatic test_reset();
        clr_inputs();
        reset_n = 1'b0;
        for (int c = 0; c < NCH; c++) set_ch(c, caddr(c), DW'(c), M_XRD, MT_W);
        mem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (cli_resp_data !== '0) begin errors++; $display("FAIL reset_resp_data got=%h exp=0", cli_resp_data); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({mem_req_valid, cli_req_ready, cli_resp_valid} !== '0) begin errors++; $display("FAIL en0_handshake got=%b/%b/%b exp=all 0", mem_req_valid, cli_req_ready, cli_resp_valid); end
        next_cyc();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (cli_req_ready !== oh(n % NCH) || mem_req_addr !== caddr(n % NCH)) begin errors++; $display("FAIL rr_order[%0d] ready=%b addr=%h exp ready=%b addr=%h", n, cli_req_ready, mem_req_addr, oh(n % NCH), caddr(n % NCH)); end
            next_cyc();
        end
    endtask

    task automatic test_stall_lock();
        do_reset();
        set_ch(1, caddr(1), 32'hD1D1_0001, M_XWR, MT_H);
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) set_ch(0, caddr(0), 32'hD0, M_XRD, MT_B);
            mem_req_ready = (c == 4);
            @(negedge clk);
            checks++; if ({mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ} !== {1'b1, caddr(1), 32'hD1D1_0001, M_XWR, MT_H}) begin errors++; $display("FAIL stall_fields[c%0d] got v=%b a=%h d=%h f=%b t=%0d exp ch1 fields", c, mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ); end
            checks++; if (cli_req_ready !== ((c == 4) ? oh(1) : 3'b000)) begin errors++; $display("FAIL stall_ready[c%0d] got=%b exp=%b", c, cli_req_ready, (c == 4) ? oh(1) : 3'b000); end
            next_cyc();
        end
        cli_req_valid[1] = 1'b0;
        @(negedge clk);
        checks++; if (cli_req_ready !== oh(0) || mem_req_addr !== caddr(0)) begin errors++; $display("FAIL stall_then_ch0 ready=%b addr=%h exp ready=001 addr=%h", cli_req_ready, mem_req_addr, caddr(0)); end
        next_cyc();
    endtask

    task automatic test_full();
        do_reset();
        set_ch(0, caddr(0), 32'h0, M_XRD, MT_W);
        mem_req_ready = 1'b1;
        for (int n = 0; n < MAX_OUT; n++) begin
            @(negedge clk);
            checks++; if (cli_req_ready !== oh(0) || int'(outstanding) != n) begin errors++; $display("FAIL fill[%0d] ready=%b out=%0d exp ready=001 out=%0d", n, cli_req_ready, outstanding, n); end
            next_cyc();
        end
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0 || int'(outstanding) != MAX_OUT) begin errors++; $display("FAIL full_block valid=%b out=%0d exp valid=0 out=%0d", mem_req_valid, outstanding, MAX_OUT); end
        next_cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h77;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0 || cli_req_ready !== 3'b000) begin errors++; $display("FAIL full_pop_same_cycle valid=%b ready=%b exp 0/000", mem_req_valid, cli_req_ready); end
        checks++; if (cli_resp_valid !== oh(0) || cli_resp_data !== 32'h77) begin errors++; $display("FAIL full_pop_resp got=%b/%h exp=001/77", cli_resp_valid, cli_resp_data); end
        next_cyc();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || cli_req_ready !== oh(0) || int'(outstanding) != MAX_OUT - 1) begin errors++; $display("FAIL after_free valid=%b ready=%b out=%0d exp 1/001/%0d", mem_req_valid, cli_req_ready, outstanding, MAX_OUT - 1); end
        next_cyc();
    endtask

    task automatic test_resp_routing();
        int ord[3] = '{2, 0, 2};
        logic [DW-1:0] rdat[3] = '{32'hA, 32'hB, 32'hC};
        do_reset();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cli_req_valid = '0;
            set_ch(ord[i], caddr(ord[i]), DW'(i), M_XRD, MT_W);
            @(negedge clk);
            checks++; if (cli_req_ready !== oh(ord[i])) begin errors++; $display("FAIL route_accept[%0d] got=%b exp=%b", i, cli_req_ready, oh(ord[i])); end
            next_cyc();
        end
        cli_req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = rdat[i];
            @(negedge clk);
            checks++; if (cli_resp_valid !== oh(ord[i]) || cli_resp_data !== rdat[i]) begin errors++; $display("FAIL route_resp[%0d] got=%b/%h exp=%b/%h", i, cli_resp_valid, cli_resp_data, oh(ord[i]), rdat[i]); end
            next_cyc();
        end
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL route_drained got=%0d exp=0", outstanding); end
        next_cyc();
    endtask

    task automatic test_same_cycle();
        do_reset();
        mem_req_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cli_req_valid = '0;
            set_ch(c, caddr(c), DW'(c), M_XRD, MT_W);
            next_cyc();
        end
        cli_req_valid = '0;
        set_ch(2, caddr(2), 32'h2, M_XWR, MT_B);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55;
        @(negedge clk);
        checks++; if (cli_resp_valid !== oh(0) || cli_resp_data !== 32'h55 || cli_req_ready !== oh(2)) begin errors++; $display("FAIL same_cycle resp=%b/%h ready=%b exp 001/55/100", cli_resp_valid, cli_resp_data, cli_req_ready); end
        next_cyc();
        cli_req_valid  = '0;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL same_cycle_count got=%0d exp=2", outstanding); end
        for (int i = 1; i <= 2; i++) begin
            next_cyc();
            mem_resp_valid = 1'b1;
            mem_resp_data  = DW'(i);
            @(negedge clk);
            checks++; if (cli_resp_valid !== oh(i)) begin errors++; $display("FAIL same_cycle_drain[%0d] got=%b exp=%b", i, cli_resp_valid, oh(i)); end
        end
        next_cyc();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_resp_err();
        do_reset();
        mem_req_ready = 1'b1;
        set_ch(0, caddr(0), 32'h0, M_XRD, MT_W);
        next_cyc();
        clr_inputs();
        reset_n = 1'b0;
        #2;
        checks++; if (outstanding !== 3'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL midreset_clear out=%0d err=%b exp 0/0", outstanding, resp_err); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        next_cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD;
        @(negedge clk);
        checks++; if (cli_resp_valid !== 3'b000) begin errors++; $display("FAIL stray_resp_strobe got=%b exp=000", cli_resp_valid); end
        next_cyc();
        mem_resp_valid = 1'b0;
        repeat (3) next_cyc();
        @(negedge clk);
        checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL resp_err_sticky got=%b exp=1", resp_err); end
        reset_n = 1'b0;
        #2;
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL resp_err_reset got=%b exp=0", resp_err); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        next_cyc();
    endtask

    // Reference: requests held until accepted, ids queued in acceptance order.
    task automatic test_random();
        int            q[$];
        int            rr, lock_ch, g;
        bit            lock, exp_mv, acc, rv;
        bit            pend[NCH];
        int            waits[NCH];
        logic [AW-1:0] ra[NCH];
        logic [DW-1:0] rd[NCH];
        logic          rf[NCH];
        logic [2:0]    rt[NCH];
        logic [DW-1:0] rdat;
        do_reset();
        rr = 0; lock = 0; lock_ch = 0;
        for (int c = 0; c < NCH; c++) begin pend[c] = 0; waits[c] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c] && ($urandom % 2 == 0)) begin
                    pend[c] = 1; waits[c] = 0;
                    ra[c] = $urandom; rd[c] = $urandom;
                    rf[c] = 1'($urandom % 2); rt[c] = 3'($urandom % 6);
                end
                if (pend[c]) set_ch(c, ra[c], rd[c], rf[c], rt[c]);
                else cli_req_valid[c] = 1'b0;
            end
            mem_req_ready  = ($urandom % 4) != 0;
            rv             = (q.size() > 0) && ($urandom % 5 < 3);
            rdat           = $urandom;
            mem_resp_valid = rv;
            mem_resp_data  = rdat;
            g = -1;
            if (lock) g = lock_ch;
            else for (int k = 0; k < NCH; k++) if (g < 0 && pend[(rr + k) % NCH]) g = (rr + k) % NCH;
            exp_mv = (g >= 0) && pend[g] && (q.size() < MAX_OUT);
            acc    = exp_mv && mem_req_ready;
            @(negedge clk);
            checks++; if (mem_req_valid !== exp_mv) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, mem_req_valid, exp_mv); end
            if (exp_mv) begin
                checks++; if ({mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ} !== {ra[g], rd[g], rf[g], rt[g]}) begin errors++; $display("FAIL rnd_fields[%0d] got a=%h d=%h exp ch%0d a=%h d=%h", cyc, mem_req_addr, mem_req_data, g, ra[g], rd[g]); end
            end
            checks++; if (cli_req_ready !== (acc ? oh(g) : 3'b000)) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, cli_req_ready, acc ? oh(g) : 3'b000); end
            checks++; if (cli_resp_valid !== (rv ? oh(q[0]) : 3'b000)) begin errors++; $display("FAIL rnd_resp[%0d] got=%b exp=%b", cyc, cli_resp_valid, rv ? oh(q[0]) : 3'b000); end
            if (rv) begin
                checks++; if (cli_resp_data !== rdat) begin errors++; $display("FAIL rnd_resp_data[%0d] got=%h exp=%h", cyc, cli_resp_data, rdat); end
            end
            checks++; if (int'(outstanding) != q.size()) begin errors++; $display("FAIL rnd_outstanding[%0d] got=%0d exp=%0d", cyc, outstanding, q.size()); end
            if (acc) begin
                checks++; if (waits[g] > NCH - 1) begin errors++; $display("FAIL rnd_fairness[%0d] ch%0d waited=%0d accepts exp<=%0d", cyc, g, waits[g], NCH - 1); end
            end
            if (rv) void'(q.pop_front());
            if (acc) begin
                q.push_back(g);
                for (int c = 0; c < NCH; c++) if (c != g && pend[c]) waits[c]++;
                pend[g] = 0;
                rr      = (g + 1) % NCH;
                lock    = 0;
            end else if (exp_mv) begin
                lock    = 1;
                lock_ch = g;
            end
            next_cyc();
        end
        clr_inputs();
        @(negedge clk);
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rnd_resp_err got=%b exp=0", resp_err); end
        next_cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        clr_inputs();
        test_reset();
        test_stall_lock();
        test_full();
        test_resp_routing();
        test_same_cycle();
        test_resp_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
